// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline stall/flush control: merges load-use and branch hazards with
// mul/div sequencing and data-memory wait states into prioritised stage controls.
module pipeline_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lw_stall_i,
  input  logic             pcsrc_e_i,
  input  logic             md_op_e_i,
  input  logic             md_done_i,
  output logic             md_start_o,
  input  logic             mem_req_m_i,
  input  logic             mem_ready_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_m_o,
  output logic             flush_w_o,
  output logic             md_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int unsigned RUN_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t        r_state;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_mem_wait;
  logic w_md_busy;
  logic w_run_last;
  logic w_md_start;

  assign w_mem_wait = mem_req_m_i & ~mem_ready_i;
  assign w_md_busy  = ((r_state == MD_IDLE) & md_op_e_i) | (r_state == MD_RUN) |
                      ((r_state == MD_DONE) & w_mem_wait);
  assign w_run_last = (r_run_cnt == RUN_W'(MD_TIMEOUT - 1));
  assign w_md_start = (r_state == MD_IDLE) & md_op_e_i & ~w_mem_wait;

  // Mul/div sequencing; a watchdog expiry completes the op and latches a sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= MD_IDLE;
      r_run_cnt    <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_md_start) begin
            r_state   <= MD_RUN;
            r_run_cnt <= '0;
          end
        end
        MD_RUN: begin
          r_run_cnt <= r_run_cnt + RUN_W'(1);
          if (md_done_i) begin
            r_state <= MD_DONE;
          end else if (w_run_last) begin
            r_md_timeout <= 1'b1;
            r_state      <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (!w_mem_wait) r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Fetch-stall performance counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (stall_f_o) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // Prioritised stage controls: memory wait freezes everything up to Memory.
  always_comb begin
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    stall_e_o  = 1'b0;
    stall_m_o  = 1'b0;
    flush_d_o  = 1'b0;
    flush_e_o  = 1'b0;
    flush_m_o  = 1'b0;
    flush_w_o  = 1'b0;
    md_start_o = w_md_start;
    if (w_mem_wait) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (w_md_busy) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      flush_m_o = 1'b1;
    end else if (pcsrc_e_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (lw_stall_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign md_timeout_o   = r_md_timeout;
  assign stall_cycles_o = r_stall_cycles;

endmodule
